// File: rtl/palette_pkg.sv
// Shared types, default palette contents and width helper for the palette engine.
// DEFAULT_PALETTE reproduces the legacy 8-color output with four shade patterns per color.
package palette_pkg;

   typedef struct packed {
      logic [1:0] r;
      logic [1:0] g;
      logic [1:0] b;
   } rgb_t;

   localparam int unsigned DEF_COLORS = 8;
   localparam int unsigned DEF_SUBPIX = 4;

   // Subpixel 0..2 are full/mid/dim shades; 3 is a pastel with the off channels at 01.
   localparam rgb_t DEFAULT_PALETTE [DEF_COLORS][DEF_SUBPIX] = '{
      '{6'b000000, 6'b000000, 6'b000000, 6'b010101},
      '{6'b000011, 6'b000010, 6'b000001, 6'b010111},
      '{6'b001100, 6'b001000, 6'b000100, 6'b011101},
      '{6'b001111, 6'b001010, 6'b000101, 6'b011111},
      '{6'b110000, 6'b100000, 6'b010000, 6'b110101},
      '{6'b110011, 6'b100010, 6'b010001, 6'b110111},
      '{6'b111100, 6'b101000, 6'b010100, 6'b111101},
      '{6'b111111, 6'b101010, 6'b010101, 6'b111111}
   };

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/palette_rotator.sv
// Frame-rate palette rotation: frame counter, rotation offset and index remap
// through the [ROT_LO, ROT_HI] window.
module palette_rotator
   import palette_pkg::*;
#(
   parameter int unsigned NUM_COLORS = 8,
   parameter int unsigned ROT_LO     = 2,
   parameter int unsigned ROT_HI     = 5,
   parameter int unsigned IDX_W      = clog2(NUM_COLORS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic             rot_en,
   input  logic             rot_clr,
   input  logic [3:0]       rot_period,
   input  logic [IDX_W-1:0] index,
   output logic [IDX_W-1:0] mapped
);

   localparam int unsigned SPAN    = ROT_HI - ROT_LO + 1;
   localparam int unsigned SPAN_M1 = SPAN - 1;
   localparam logic [IDX_W-1:0] OFF_MAX = SPAN_M1[IDX_W-1:0];
   localparam logic [IDX_W:0]   LO_X    = ROT_LO[IDX_W:0];
   localparam logic [IDX_W:0]   HI_X    = ROT_HI[IDX_W:0];
   localparam logic [IDX_W:0]   SPAN_X  = SPAN[IDX_W:0];
   localparam logic [IDX_W-1:0] LO_N    = ROT_LO[IDX_W-1:0];

   logic [3:0]       fcnt_q, fcnt_d;
   logic [IDX_W-1:0] rot_off_q, rot_off_d;
   logic [IDX_W:0]   idx_x, sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q    <= '0;
         rot_off_q <= '0;
      end else begin
         fcnt_q    <= fcnt_d;
         rot_off_q <= rot_off_d;
      end
   end

   always_comb begin
      fcnt_d    = fcnt_q;
      rot_off_d = rot_off_q;
      if (rot_clr) begin
         fcnt_d    = '0;
         rot_off_d = '0;
      end else if (!rot_en) begin
         fcnt_d = '0;
      end else if (frame_start) begin
         if (fcnt_q == rot_period) begin
            fcnt_d    = '0;
            rot_off_d = (rot_off_q == OFF_MAX) ? '0 : rot_off_q + 1'b1;
         end else begin
            fcnt_d = fcnt_q + 4'd1;
         end
      end
   end

   // One extra bit keeps index-ROT_LO+rot_off (< 2*SPAN) from overflowing.
   always_comb begin
      idx_x  = {1'b0, index};
      sum    = '0;
      mapped = index;
      if (idx_x >= LO_X && idx_x <= HI_X) begin
         sum = idx_x - LO_X + {1'b0, rot_off_q};
         if (sum >= SPAN_X) sum = sum - SPAN_X;
         mapped = LO_N + sum[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/palette_engine.sv
// Writable, rotatable palette lookup between the pattern generator and the VGA pins.
// Stage 1 remaps and registers the pixel; stage 2 reads the palette into the RGB registers.
module palette_engine
   import palette_pkg::*;
#(
   parameter int unsigned NUM_COLORS = 8,
   parameter int unsigned SUBPIX     = 4,
   parameter int unsigned BPC        = 2,
   parameter int unsigned ROT_LO     = 2,
   parameter int unsigned ROT_HI     = 5,
   parameter int unsigned IDX_W      = clog2(NUM_COLORS),
   parameter int unsigned SUB_W      = clog2(SUBPIX)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_valid,
   input  logic             blank,
   input  logic [IDX_W-1:0] index,
   input  logic [SUB_W-1:0] subpixel,
   input  logic             frame_start,
   input  logic             rot_en,
   input  logic             rot_clr,
   input  logic [3:0]       rot_period,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_index,
   input  logic [SUB_W-1:0] wr_sub,
   input  logic [3*BPC-1:0] wr_data,
   output logic [BPC-1:0]   r,
   output logic [BPC-1:0]   g,
   output logic [BPC-1:0]   b,
   output logic             rgb_valid
);

   localparam int unsigned CW = 3 * BPC;
   localparam logic [IDX_W:0] NC_X = NUM_COLORS[IDX_W:0];

   // Channel bits are taken cyclically from the 2-bit defaults so any BPC resets sensibly.
   function automatic logic [CW-1:0] widen(input rgb_t c);
      logic [CW-1:0] res;
      res = '0;
      for (int ch = 0; ch < 3; ch++)
         for (int k = 0; k < int'(BPC); k++)
            res[ch*BPC + k] = c[ch*2 + (k % 2)];
      return res;
   endfunction

   logic [CW-1:0]    pal_q [NUM_COLORS][SUBPIX];
   logic [IDX_W-1:0] mapped;
   logic             s1_valid_q, s1_blank_q, s1_oor_q;
   logic [IDX_W-1:0] s1_mapped_q;
   logic [SUB_W-1:0] s1_sub_q;
   logic [CW-1:0]    rd, rgb_q;

   palette_rotator #(
      .NUM_COLORS (NUM_COLORS),
      .ROT_LO     (ROT_LO),
      .ROT_HI     (ROT_HI),
      .IDX_W      (IDX_W)
   ) u_rot (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .rot_en      (rot_en),
      .rot_clr     (rot_clr),
      .rot_period  (rot_period),
      .index       (index),
      .mapped      (mapped)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_COLORS); i++)
            for (int s = 0; s < int'(SUBPIX); s++)
               pal_q[i][s] <= widen(DEFAULT_PALETTE[i % DEF_COLORS][s % DEF_SUBPIX]);
      end else if (wr_en && ({1'b0, wr_index} < NC_X)) begin
         pal_q[wr_index][wr_sub] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_blank_q  <= 1'b0;
         s1_oor_q    <= 1'b0;
         s1_mapped_q <= '0;
         s1_sub_q    <= '0;
         rgb_q       <= '0;
         rgb_valid   <= 1'b0;
      end else begin
         s1_valid_q  <= pix_valid;
         s1_blank_q  <= blank;
         s1_oor_q    <= ({1'b0, index} >= NC_X);
         s1_mapped_q <= mapped;
         s1_sub_q    <= subpixel;
         rgb_q       <= rd;
         rgb_valid   <= s1_valid_q;
      end
   end

   // Read sees the palette as it was before any write landing on the same edge.
   always_comb begin
      rd = '0;
      if (s1_valid_q && !s1_blank_q && !s1_oor_q) rd = pal_q[s1_mapped_q][s1_sub_q];
   end

   assign r = rgb_q[CW-1 -: BPC];
   assign g = rgb_q[2*BPC-1 -: BPC];
   assign b = rgb_q[BPC-1:0];

endmodule

// File: tb/tb_palette_engine.sv
// Directed self-checking bench for palette_engine: table-driven pixel stream plus
// hand-written write, rotation, priority and async-reset sequences.
module tb_palette_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_valid, blank, frame_start, rot_en, rot_clr, wr_en;
   logic [2:0] index, wr_index;
   logic [1:0] subpixel, wr_sub;
   logic [3:0] rot_period;
   logic [5:0] wr_data;
   logic [1:0] r, g, b;
   logic       rgb_valid;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0] idx;
      logic [1:0] sub;
      logic       blk;
      logic       vld;
      logic [5:0] exp_rgb;
      logic       exp_vld;
   } vec_t;

   vec_t vecs [8];

   palette_engine dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_valid   (pix_valid),
      .blank       (blank),
      .index       (index),
      .subpixel    (subpixel),
      .frame_start (frame_start),
      .rot_en      (rot_en),
      .rot_clr     (rot_clr),
      .rot_period  (rot_period),
      .wr_en       (wr_en),
      .wr_index    (wr_index),
      .wr_sub      (wr_sub),
      .wr_data     (wr_data),
      .r           (r),
      .g           (g),
      .b           (b),
      .rgb_valid   (rgb_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [6:0] exp);
      logic [6:0] act;
      act = {r, g, b, rgb_valid};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got rgb=%b valid=%b, want rgb=%b valid=%b",
                  name, act[6:1], act[0], exp[6:1], exp[0]);
      end
   endtask

   // Single isolated pixel; outputs hold its result on return.
   task automatic pixel(input logic [2:0] i, input logic [1:0] s);
      index = i; subpixel = s; blank = 1'b0; pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      tick();
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; pix_valid = 1'b0; blank = 1'b0; index = '0; subpixel = '0;
      frame_start = 1'b0; rot_en = 1'b0; rot_clr = 1'b0; rot_period = '0;
      wr_en = 1'b0; wr_index = '0; wr_sub = '0; wr_data = '0;

      vecs[0] = '{3'd3, 2'd1, 1'b0, 1'b1, 6'b001010, 1'b1};
      vecs[1] = '{3'd4, 2'd0, 1'b1, 1'b1, 6'b000000, 1'b1};
      vecs[2] = '{3'd7, 2'd3, 1'b0, 1'b1, 6'b111111, 1'b1};
      vecs[3] = '{3'd5, 2'd2, 1'b0, 1'b1, 6'b010001, 1'b1};
      vecs[4] = '{3'd6, 2'd0, 1'b0, 1'b0, 6'b000000, 1'b0};
      vecs[5] = '{3'd2, 2'd3, 1'b0, 1'b1, 6'b011101, 1'b1};
      vecs[6] = '{3'd1, 2'd0, 1'b0, 1'b1, 6'b000011, 1'b1};
      vecs[7] = '{3'd0, 2'd3, 1'b0, 1'b1, 6'b010101, 1'b1};

      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("reset_outputs", 7'b0);

      // Back-to-back stream: result of vector k appears two edges after it is sampled.
      for (int k = 0; k < 8; k++) begin
         index = vecs[k].idx; subpixel = vecs[k].sub;
         blank = vecs[k].blk; pix_valid = vecs[k].vld;
         tick();
         if (k > 0) chk($sformatf("stream_%0d", k - 1), {vecs[k-1].exp_rgb, vecs[k-1].exp_vld});
      end
      pix_valid = 1'b0; blank = 1'b0;
      tick();
      chk("stream_7", {vecs[7].exp_rgb, vecs[7].exp_vld});

      // Write 7/2: stage-2 read on the write edge sees the old value, later pixel sees new.
      index = 3'd7; subpixel = 2'd2; pix_valid = 1'b1;
      tick();
      wr_en = 1'b1; wr_index = 3'd7; wr_sub = 2'd2; wr_data = 6'b110011;
      tick();
      wr_en = 1'b0;
      chk("write_same_edge_old", {6'b010101, 1'b1});
      tick();
      pix_valid = 1'b0;
      tick();
      chk("write_readback_new", {6'b110011, 1'b1});

      // Rotation with period 1: 4 frames -> offset 2.
      rot_en = 1'b1; rot_period = 4'd1;
      repeat (4) frame();
      pixel(3'd5, 2'd0); chk("rot2_idx5", {6'b001111, 1'b1});
      pixel(3'd1, 2'd0); chk("rot2_idx1", {6'b000011, 1'b1});
      pixel(3'd6, 2'd0); chk("rot2_idx6", {6'b111100, 1'b1});
      pixel(3'd2, 2'd0); chk("rot2_idx2", {6'b110000, 1'b1});
      repeat (2) frame();
      pixel(3'd5, 2'd1); chk("rot3_idx5", {6'b100000, 1'b1});
      repeat (2) frame();
      pixel(3'd3, 2'd1); chk("rot_wrap_idx3", {6'b001010, 1'b1});

      // Period 0 steps every frame.
      rot_period = 4'd0;
      frame();
      pixel(3'd2, 2'd0); chk("period0_step", {6'b001111, 1'b1});

      // rot_clr beats a frame_start that would otherwise step.
      rot_period = 4'd1;
      frame();
      frame_start = 1'b1; rot_clr = 1'b1;
      tick();
      frame_start = 1'b0; rot_clr = 1'b0;
      tick();
      pixel(3'd2, 2'd0); chk("clr_offset", {6'b001100, 1'b1});
      frame();
      pixel(3'd2, 2'd0); chk("clr_fcnt", {6'b001100, 1'b1});
      frame();
      pixel(3'd2, 2'd0); chk("step_after_clr", {6'b001111, 1'b1});

      // rot_en=0 holds the offset and clears the frame counter.
      frame();
      rot_en = 1'b0;
      repeat (3) frame();
      pixel(3'd2, 2'd0); chk("disabled_hold", {6'b001111, 1'b1});
      rot_en = 1'b1;
      frame();
      pixel(3'd2, 2'd0); chk("disabled_fcnt_clr", {6'b001111, 1'b1});

      // Async reset between edges while a valid pixel is on the outputs.
      index = 3'd2; subpixel = 2'd0; pix_valid = 1'b1;
      tick(); tick();
      chk("pre_reset_stream", {6'b001111, 1'b1});
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_out", 7'b0);
      pix_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_release_idle", 7'b0);
      pixel(3'd2, 2'd0); chk("reset_rot_off", {6'b001100, 1'b1});
      pixel(3'd7, 2'd2); chk("reset_palette", {6'b010101, 1'b1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/palette_engine.md
# palette_engine

Programmable, animatable successor to the fixed 8-color palette lookup in the pixel output path. Holds a writable palette of NUM_COLORS entries × SUBPIX subpixel patterns × 3 channels of BPC bits. It remaps indices through a frame-rate palette-rotation window and drives registered RGB with a fixed 2-cycle latency. It sits between the sprite/pattern generator (index + subpixel) and the VGA output pins.

## Interface
Parameters:
- NUM_COLORS, 8, palette entries (2..16); IDX_W = clog2(NUM_COLORS)
- SUBPIX, 4, subpixel patterns per entry (power of two); SUB_W = clog2(SUBPIX)
- BPC, 2, bits per channel
- ROT_LO, 2, first index of rotation window
- ROT_HI, 5, last index of rotation window (ROT_LO < ROT_HI < NUM_COLORS)

Ports:
- clk  in  1  pixel clock; one clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  index/subpixel valid this cycle
- blank  in  1  force black output for this pixel
- index  in  IDX_W  palette index
- subpixel  in  SUB_W  subpixel pattern select
- frame_start  in  1  one-cycle pulse at start of frame
- rot_en  in  1  rotation advance enable
- rot_clr  in  1  synchronous clear of rotation offset
- rot_period  in  4  frames per rotation step minus one
- wr_en  in  1  palette write strobe
- wr_index  in  IDX_W  entry to write
- wr_sub  in  SUB_W  subpixel slot to write
- wr_data  in  3*BPC  {r,g,b} value
- r, g, b  out  BPC each  registered color
- rgb_valid  out  1  r/g/b correspond to a valid input pixel

## Operation
- Storage: NUM_COLORS×SUBPIX flops of 3*BPC bits. On reset, loaded from package constant DEFAULT_PALETTE.
- Write: on wr_en, entry[wr_index][wr_sub] ← wr_data at the clock edge. wr_index ≥ NUM_COLORS: ignored. A read of the same entry in the same cycle returns the old value.
- Rotation state: frame counter fcnt (4 b), offset rot_off (0..SPAN-1, SPAN = ROT_HI-ROT_LO+1).
  - Priority 1: rot_clr → rot_off=0, fcnt=0.
  - Priority 2: rot_en=0 → fcnt=0, rot_off held.
  - Priority 3: frame_start & rot_en → if fcnt==rot_period, then fcnt=0 and rot_off=(rot_off+1) mod SPAN; else fcnt+1.
  - rot_period=0 gives a step every frame.
- Remap (stage 1): if ROT_LO ≤ index ≤ ROT_HI, mapped = ROT_LO + ((index-ROT_LO+rot_off) mod SPAN); otherwise mapped = index. Uses rot_off as registered before that edge. Computed at IDX_W+1 bits, no overflow.
- Lookup (stage 2): {r,g,b} = entry[mapped][sub]. Output is 0 if the stage-1 blank is set, pix_valid is 0, or index ≥ NUM_COLORS.
- rgb_valid = pix_valid delayed 2 cycles (blank does not clear it).

## Timing
- Reset values: r=g=b=0, rgb_valid=0, rot_off=0, fcnt=0, pipeline regs 0, palette=DEFAULT_PALETTE.
- Latency: input at edge N appears on outputs after edge N+2. Throughput is 1 pixel per clock, with no stalls.
- Write at edge N is visible to a pixel sampled at edge N+1 or later (stage-2 read after the write edge).
- rot_off change at edge N affects pixels sampled at edge N+1 onward.
- Reset asserted mid-frame: all state returns to reset values immediately. Outputs read 0 until two valid pixels after release.

## Structure
- Package palette_pkg: DEFAULT_PALETTE constant (parametrisable array, 8×4×6 b default matching the existing hardware colors), rgb_t typedef, clog2 helper.
- Sub-module palette_rotator: fcnt/rot_off state and remap function. The top level keeps the storage, write port and 2-stage pipeline.

## Test plan
- Reset defaults: index=3, sub=1, pix_valid=1 after reset → 2 cycles later {r,g,b}=DEFAULT_PALETTE[3][1], rgb_valid=1.
- Write/readback: wr_en with index 7, sub 2, data 6'b110011, then read 7/2 next cycle → r=2'b11, g=2'b00, b=2'b11. A same-cycle read returns the old value.
- Rotation: rot_en=1, rot_period=1, 4 frame_start pulses → rot_off=2. Index 5 then reads entry 3; index 1 and index 6 are unchanged. rot_off wraps 3→0 after 8 pulses.
- Priority: rot_clr and frame_start in the same cycle → rot_off=0, fcnt=0. rot_en=0 for 3 frames → rot_off held.
- Blank/invalid: blank=1 with index 4 → rgb=0, rgb_valid=1. pix_valid=0 → rgb=0, rgb_valid=0.
- Async reset mid-stream: assert rst_n=0 between edges → outputs 0 immediately, and rot_off and palette revert to default.
